// File: rtl/twire_pkg.sv
// twire_pkg: shared definitions for the two-wire (I2C) sensor link.
//   SYSCLK / I2CCLK      : system and bus clock rates in Hz
//   SLAVE_WR/RD_ADDR     : slave address bytes for write and read transactions
//   operation_t          : command operation handed to the master core
//   seq_state_t          : states of the configuration sequencer
//   TBL_END, TBL_DLY_TAG : special table entries (terminator, delay tag)
package twire_pkg;

  localparam int unsigned SYSCLK = 100_000_000;
  localparam int unsigned I2CCLK = 400_000;

  localparam logic [7:0] SLAVE_WR_ADDR = 8'h20;
  localparam logic [7:0] SLAVE_RD_ADDR = 8'h21;

  typedef enum logic {
    wr_op = 1'b0,
    rd_op = 1'b1
  } operation_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ROMW,
    S_DECODE,
    S_WR_REQ,
    S_WR_RSP,
    S_RD_REQ,
    S_RD_RSP,
    S_RETRY,
    S_ADV,
    S_DELAY,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam logic [15:0] TBL_END     = 16'hFFFF;
  localparam logic [7:0]  TBL_DLY_TAG = 8'hFE;

endpackage

// File: rtl/twire_cfg_delay.sv
// twire_cfg_delay: loadable down-counter used for timed delay table entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : load i_load_val (has priority over decrement)
//   i_load_val  : value to load
//   i_dec       : decrement by one; the counter holds at zero
//   o_zero      : counter is zero
module twire_cfg_delay #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/twire_cfg_seq.sv
// twire_cfg_seq: walks a {reg, val} table in a synchronous ROM and issues one
// write (plus optional readback/compare) per entry to the two-wire master.
//   clk, rst_n              : clock, asynchronous active-low reset
//   start / abort           : single-cycle control pulses
//   tbl_addr / tbl_data     : ROM port, data valid one cycle after address
//   cmd_*                   : valid/ready command channel to the master
//   rsp_valid/nack/rdata    : transaction completion from the master
//   busy, done, error       : status (done/error sticky until next start)
//   err_idx                 : table index of the failing or aborted entry
module twire_cfg_seq
  import twire_pkg::*;
#(
  parameter int TBL_AW     = 8,
  parameter int MAX_RETRY  = 3,
  parameter int VERIFY     = 1,
  parameter int CYC_PER_MS = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output operation_t        cmd_op,
  output logic [7:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  input  logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int DLY_W = $clog2(255 * CYC_PER_MS + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  seq_state_t        r_state;
  logic [TBL_AW-1:0] r_index;
  logic [7:0]        r_reg;
  logic [7:0]        r_val;
  logic [RTY_W-1:0]  r_retry;
  logic              r_abort_pend;
  logic              r_cmd_valid;
  operation_t        r_cmd_op;
  logic [7:0]        r_cmd_dev;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [TBL_AW-1:0] r_err_idx;

  logic              w_abort;
  logic              w_take_abort;
  logic              w_dly_zero;
  logic [DLY_W-1:0]  w_dly_load_val;

  // The counter runs load_val..0, so a delay of N cycles loads N-1.
  // A zero-length delay never enters DELAY, so the underflow is unused.
  assign w_dly_load_val = DLY_W'(r_val) * DLY_W'(CYC_PER_MS) - DLY_W'(1);

  twire_cfg_delay #(.W(DLY_W)) u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_state == S_DECODE),
    .i_load_val (w_dly_load_val),
    .i_dec      (r_state == S_DELAY),
    .o_zero     (w_dly_zero)
  );

  assign w_abort = abort | r_abort_pend;

  // Safe points for an abort. A request is only withdrawn if the master has
  // not accepted it this cycle; an outstanding transaction must complete.
  always_comb begin
    w_take_abort = 1'b0;
    if (w_abort) begin
      case (r_state)
        S_FETCH, S_DECODE, S_DELAY, S_ADV: w_take_abort = 1'b1;
        S_WR_REQ, S_RD_REQ:                w_take_abort = !cmd_ready;
        S_WR_RSP, S_RD_RSP:                w_take_abort = rsp_valid;
        default:                           w_take_abort = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_reg        <= '0;
      r_val        <= '0;
      r_retry      <= '0;
      r_abort_pend <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_op     <= wr_op;
      r_cmd_dev    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_idx    <= '0;
    end else begin
      if (abort && r_busy) r_abort_pend <= 1'b1;

      if (w_take_abort) begin
        r_state      <= S_ERROR;
        r_cmd_valid  <= 1'b0;
        r_busy       <= 1'b0;
        r_error      <= 1'b1;
        r_err_idx    <= r_index;
        r_abort_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              r_state      <= S_FETCH;
              r_index      <= '0;
              r_retry      <= '0;
              r_abort_pend <= 1'b0;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
              r_error      <= 1'b0;
              r_err_idx    <= '0;
            end
          end
          S_FETCH: r_state <= S_ROMW;
          S_ROMW: begin
            r_reg   <= tbl_data[15:8];
            r_val   <= tbl_data[7:0];
            r_state <= S_DECODE;
          end
          S_DECODE: begin
            if ({r_reg, r_val} == TBL_END) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_reg == TBL_DLY_TAG) begin
              r_state <= (r_val == 8'd0) ? S_ADV : S_DELAY;
            end else begin
              r_state     <= S_WR_REQ;
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= wr_op;
              r_cmd_dev   <= SLAVE_WR_ADDR;
            end
          end
          S_WR_REQ: begin
            if (cmd_ready) begin
              r_cmd_valid <= 1'b0;
              r_state     <= S_WR_RSP;
            end
          end
          S_WR_RSP: begin
            if (rsp_valid) begin
              if (rsp_nack) begin
                r_state <= S_RETRY;
              end else if (VERIFY != 0) begin
                r_state     <= S_RD_REQ;
                r_cmd_valid <= 1'b1;
                r_cmd_op    <= rd_op;
                r_cmd_dev   <= SLAVE_RD_ADDR;
              end else begin
                r_state <= S_ADV;
              end
            end
          end
          S_RD_REQ: begin
            if (cmd_ready) begin
              r_cmd_valid <= 1'b0;
              r_state     <= S_RD_RSP;
            end
          end
          S_RD_RSP: begin
            if (rsp_valid) begin
              r_state <= (rsp_nack || (rsp_rdata != r_val)) ? S_RETRY : S_ADV;
            end
          end
          S_RETRY: begin
            // A retry always restarts with the write, never the read alone.
            if (r_retry < RTY_W'(MAX_RETRY)) begin
              r_retry     <= r_retry + RTY_W'(1);
              r_state     <= S_WR_REQ;
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= wr_op;
              r_cmd_dev   <= SLAVE_WR_ADDR;
            end else begin
              r_state   <= S_ERROR;
              r_busy    <= 1'b0;
              r_error   <= 1'b1;
              r_err_idx <= r_index;
            end
          end
          S_ADV: begin
            r_retry <= '0;
            // Running off the last table slot counts as end of table.
            if (r_index == '1) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_index <= r_index + TBL_AW'(1);
              r_state <= S_FETCH;
            end
          end
          S_DELAY: begin
            if (w_dly_zero) r_state <= S_ADV;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tbl_addr  = r_index;
  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign cmd_dev   = r_cmd_dev;
  assign cmd_reg   = r_reg;
  assign cmd_wdata = r_val;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_idx   = r_err_idx;

endmodule

// File: tb/tb_twire_cfg_seq.sv
module tb_twire_cfg_seq;
  import twire_pkg::*;

  localparam int TBL_AW    = 4;
  localparam int N         = 16;
  localparam int MAX_RETRY = 3;
  localparam int CYC       = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       tbl_data;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  operation_t        cmd_op;
  logic [7:0]        cmd_dev, cmd_reg, cmd_wdata;
  logic              rsp_valid = 1'b0;
  logic              rsp_nack = 1'b0;
  logic [7:0]        rsp_rdata = 8'h00;
  logic              busy, done, error;
  logic [TBL_AW-1:0] err_idx;

  always #5 clk = ~clk;

  twire_cfg_seq #(
    .TBL_AW(TBL_AW), .MAX_RETRY(MAX_RETRY), .VERIFY(1), .CYC_PER_MS(CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  // Synchronous table ROM
  logic [15:0] rom [N];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: {op, dev, reg, wdata}
  logic [24:0] exp_q[$];
  bit          e_done, e_err;
  int          e_idx;

  // Slave configuration
  int         lat_fix = 0;
  int         stall = 0;
  int         ready_pct = 70;
  bit         f_en = 0;
  bit         f_bad = 0;
  logic [7:0] f_reg = 8'h00;
  int         f_nacks = 0;

  // Slave state
  logic [7:0]  smem [256];
  int          nack_left = 0;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          wr_f = 0;
  bit          outst = 0;
  int          cnt = 0;
  bit          p_nack;
  logic [7:0]  p_rdata;
  bit          hold = 0;
  logic [24:0] held;

  // Behavioural model: one write per entry, readback compare, bounded retries.
  task automatic build_model();
    int nl;
    bit ok;
    logic [7:0] r, v;
    nl = f_nacks;
    nack_left = f_nacks;
    e_done = 0; e_err = 0; e_idx = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      r = rom[i][15:8];
      v = rom[i][7:0];
      if (rom[i] == 16'hFFFF) begin e_done = 1; return; end
      if (r == 8'hFE) continue;
      ok = 0;
      for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
        exp_q.push_back({wr_op, 8'h20, r, v});
        if (f_en && r == f_reg && nl > 0) nl--;
        else begin
          exp_q.push_back({rd_op, 8'h21, r, v});
          ok = !(f_en && f_bad && r == f_reg);
        end
      end
      if (!ok) begin e_err = 1; e_idx = i; return; end
    end
    e_done = 1;  // ran off the end of the table
  endtask

  // Slave + monitor: decides cmd_ready, checks accepted commands, responds.
  initial begin
    logic [24:0] e;
    for (int i = 0; i < 256; i++) smem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outst = 0; cnt = 0; rsp_valid = 0; rsp_nack = 0; cmd_ready = 0; hold = 0;
        continue;
      end
      rsp_valid = 0; rsp_nack = 0;
      if (outst) begin
        cnt--;
        if (cnt == 0) begin
          rsp_valid = 1; rsp_nack = p_nack; rsp_rdata = p_rdata;
          outst = 0; rsp_cnt++;
        end
      end
      if (outst || rsp_valid) cmd_ready = 0;
      else if (stall > 0 && cmd_valid) begin cmd_ready = 0; stall--; end
      else cmd_ready = ($urandom_range(0, 99) < ready_pct);

      if (cmd_valid) begin
        if (hold) chk("cmd_stable", {cmd_op, cmd_dev, cmd_reg, cmd_wdata}, held);
        held = {cmd_op, cmd_dev, cmd_reg, cmd_wdata};
        hold = 1;
      end else hold = 0;

      if (cmd_valid && cmd_ready) begin
        hold = 0;
        chk("cmd_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cmd_op_dev_reg", {cmd_op, cmd_dev, cmd_reg}, e[24:8]);
          if (e[24] == wr_op) chk("cmd_wdata", cmd_wdata, e[7:0]);
        end
        if (cmd_op == wr_op) begin
          if (f_en && cmd_reg == f_reg) wr_f++;
          p_nack = f_en && cmd_reg == f_reg && nack_left > 0;
          if (p_nack) nack_left--;
          else smem[cmd_reg] = cmd_wdata;
          p_rdata = 8'h00;
        end else begin
          p_nack = 0;
          p_rdata = smem[cmd_reg] ^ ((f_en && f_bad && cmd_reg == f_reg) ? 8'h01 : 8'h00);
        end
        outst = 1;
        cnt = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4);
        acc_cnt++;
      end
    end
  end

  task automatic load_rom(input logic [15:0] a, b, c, d);
    for (int i = 0; i < N; i++) rom[i] = 16'hFFFF;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic fill_random(input int n, input bit term);
    for (int i = 0; i < N; i++) begin
      if (i < n) begin
        if ($urandom_range(0, 4) == 0) rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
        else rom[i] = {8'(i * 16 + $urandom_range(0, 13)), 8'($urandom)};
      end else rom[i] = term ? 16'hFFFF : {8'(i * 16 + $urandom_range(0, 13)), 8'($urandom)};
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1;
    @(negedge clk); #1 start = 0;
  endtask

  // Runs one sequence; reports start-to-first-cmd latency, cycles spent on
  // table index `watch`, whether a command appeared there, and timeout.
  task automatic run_seq(input int watch, input int poke, output int first,
                         output int wcyc, output bit wcmd, output bit to);
    int k;
    first = 0; wcyc = 0; wcmd = 0;
    pulse_start();
    k = 1;
    while (busy && k < 4000) begin
      if (cmd_valid && first == 0) first = k;
      if (32'(tbl_addr) == watch) begin wcyc++; if (cmd_valid) wcmd = 1; end
      @(negedge clk); #1;
      k++;
      start = (k == poke);
    end
    start = 0;
    to = busy;
  endtask

  task automatic check_end(input string name, input bit to);
    chk({name, "_timeout"}, 32'(to), 0);
    chk({name, "_done"}, 32'(done), 32'(e_done));
    chk({name, "_error"}, 32'(error), 32'(e_err));
    chk({name, "_err_idx"}, 32'(err_idx), e_idx);
    chk({name, "_cmds_left"}, exp_q.size(), 0);
    $display("%s: done=%0d error=%0d err_idx=%0d checks=%0d", name, done, error, err_idx, n_chk);
  endtask

  task automatic clear_cfg();
    f_en = 0; f_bad = 0; f_nacks = 0; f_reg = 8'h00; stall = 0; lat_fix = 0; wr_f = 0;
  endtask

  initial begin
    int first, wc, a0, r0, k;
    bit wcmd, to, early;

    for (int i = 0; i < N; i++) rom[i] = 16'hFFFF;
    #12;
    chk("reset_outputs", {busy, done, error, cmd_valid, tbl_addr, err_idx}, 0);
    @(negedge clk); #1 rst_n = 1;

    // T1: basic write + readback
    clear_cfg();
    load_rom(16'h1280, 16'h0C04, 16'hFFFF, 16'hFFFF);
    build_model();
    chk("t1_model_cmds", exp_q.size(), 4);
    run_seq(-1, 0, first, wc, wcmd, to);
    chk("t1_first_cmd_latency", first, 4);
    chk("t1_busy", 32'(busy), 0);
    check_end("t1", to);

    // T2a: two NACKs then success
    clear_cfg();
    f_en = 1; f_reg = 8'h12; f_nacks = 2;
    build_model();
    run_seq(-1, 0, first, wc, wcmd, to);
    chk("t2a_writes", wr_f, 3);
    check_end("t2a", to);

    // T2b: four NACKs exhaust retries
    clear_cfg();
    f_en = 1; f_reg = 8'h12; f_nacks = 4;
    build_model();
    run_seq(-1, 0, first, wc, wcmd, to);
    chk("t2b_writes", wr_f, 4);
    chk("t2b_error", 32'(error), 1);
    check_end("t2b", to);

    // T3: readback mismatch on every try
    clear_cfg();
    f_en = 1; f_reg = 8'h12; f_bad = 1;
    build_model();
    run_seq(-1, 0, first, wc, wcmd, to);
    chk("t3_writes", wr_f, 4);
    chk("t3_error", 32'(error), 1);
    check_end("t3", to);

    // T4: delay entry of 2 ms and of 0 ms
    clear_cfg();
    load_rom(16'h1280, 16'hFE02, 16'h0C04, 16'hFFFF);
    build_model();
    run_seq(1, 0, first, wc, wcmd, to);
    chk("t4_delay_idx_cycles", wc, 4 + 2 * CYC);
    chk("t4_delay_no_cmd", 32'(wcmd), 0);
    check_end("t4", to);
    load_rom(16'h1280, 16'hFE00, 16'h0C04, 16'hFFFF);
    build_model();
    run_seq(1, 0, first, wc, wcmd, to);
    chk("t4_zero_delay_cycles", wc, 4);
    check_end("t4z", to);

    // T5: stalled handshake, then abort while the write is outstanding
    clear_cfg();
    load_rom(16'h1280, 16'h0C04, 16'hFFFF, 16'hFFFF);
    exp_q.delete();
    exp_q.push_back({wr_op, 8'h20, 8'h12, 8'h80});
    e_done = 0; e_err = 1; e_idx = 0;
    lat_fix = 6; stall = 5;
    a0 = acc_cnt; r0 = rsp_cnt;
    pulse_start();
    k = 0;
    while (acc_cnt == a0 && k < 200) begin @(negedge clk); #1; k++; end
    abort = 1;
    @(negedge clk); #1 abort = 0;
    early = 0; k = 0;
    while (rsp_cnt == r0 && k < 200) begin
      if (error) early = 1;
      @(negedge clk); #1; k++;
    end
    chk("t5_error_deferred", 32'(early), 0);
    @(negedge clk); #1;
    chk("t5_busy", 32'(busy), 0);
    check_end("t5", (k >= 200));

    // T6: reset during readback, restart, start while busy ignored
    clear_cfg();
    lat_fix = 4;
    build_model();
    a0 = acc_cnt;
    pulse_start();
    k = 0;
    while (acc_cnt < a0 + 2 && k < 200) begin @(negedge clk); #1; k++; end
    chk("t6_reached_read", 32'(k < 200), 1);
    @(negedge clk); #1 rst_n = 0;
    #1 chk("t6_async_reset", {busy, done, error, cmd_valid, tbl_addr, err_idx}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    lat_fix = 0;
    build_model();
    run_seq(-1, 6, first, wc, wcmd, to);
    chk("t6_restart_latency", first, 4);
    check_end("t6", to);

    // T7: full table without terminator wraps to done
    clear_cfg();
    fill_random(N, 0);
    for (int i = 0; i < N; i++) if (rom[i][15:8] == 8'hFE) rom[i] = {8'(i * 16), 8'h5A};
    build_model();
    chk("t7_model_cmds", exp_q.size(), 2 * N);
    run_seq(-1, 0, first, wc, wcmd, to);
    check_end("t7", to);

    // T8: random tables and fault policies
    for (int t = 0; t < 6; t++) begin
      clear_cfg();
      fill_random($urandom_range(1, 6), 1);
      f_en = $urandom_range(0, 1);
      f_reg = rom[0][15:8];
      f_nacks = $urandom_range(0, 4);
      f_bad = ($urandom_range(0, 3) == 0);
      build_model();
      run_seq(-1, 0, first, wc, wcmd, to);
      check_end($sformatf("t8_%0d", t), to);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
